axi_lite_master: RTL and testbench
==================================

Name: axi_lite_master

Overview:
- Single-outstanding AXI4-Lite master that converts a one-cycle `start` command into one 32-bit write transaction (AW/W/B channels) or one read transaction (AR/R channels).
- Sits between local control logic and an AXI4-Lite slave.
- Reports completion with a one-cycle `done` pulse, returns read data, and flags a non-OKAY response on `error`.

Parameters:
- None. Address and data are fixed at 32 bits; strobe is fixed at 4 bits.

Ports:
- clk        in   1   clock; all logic on the rising edge
- rst_n      in   1   reset, asynchronous, active-low
- start      in   1   command strobe; sampled only in IDLE
- we_i       in   1   1 = write, 0 = read; latched with start
- addr_i     in   32  transaction address; latched with start
- data_i     in   32  write data; latched with start
- addr_o     out  32  address shared by AW and AR channels (latched value)
- data_o     out  32  W channel data (latched value)
- wstrb_o    out  4   write strobe
- awvalid_o  out  1   AW valid
- awready_i  in   1   AW ready
- wvalid_o   out  1   W valid
- wready_i   in   1   W ready
- bresp_i    in   2   B response
- bvalid_i   in   1   B valid
- bready_o   out  1   B ready
- arvalid_o  out  1   AR valid
- arready_i  in   1   AR ready
- data_i_r   in   32  R data
- rresp_i    in   2   R response
- rvalid_i   in   1   R valid
- rready_o   out  1   R ready
- data_o_r   out  32  captured read data
- error      out  1   last transaction response != OKAY (2'b00)
- done       out  1   one-cycle completion pulse

Behaviour:
- Reset:
  - All outputs are registered and reset to 0.
  - FSM returns to IDLE; latched address/data are cleared.
  - Reset mid-transaction aborts it with no done pulse.
- FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA.
- IDLE:
  - On start=1, latch we_i, addr_i and data_i, and drive addr_o and data_o from the latched values.
  - Clear error.
  - Go to WR_ADDR_DATA if we=1, else RD_ADDR.
  - start is ignored in every other state.
- WR_ADDR_DATA:
  - awvalid_o=1, wvalid_o=1 and wstrb_o=4'hF from the first cycle after start.
  - Each channel completes independently. A channel's valid drops on the edge where valid&&ready is seen, and a completed channel is not re-asserted.
  - When both are complete (same or different cycles), go to WR_RESP.
  - wstrb_o returns to 0 when W completes.
- WR_RESP:
  - bready_o=1 throughout this state; bvalid_i may be a single-cycle pulse.
  - On bvalid_i&&bready_o: bready_o<=0, error<=(bresp_i!=2'b00), done<=1 for one cycle, go to IDLE.
- RD_ADDR:
  - arvalid_o=1 until arvalid_o&&arready_i, then drop it and go to RD_DATA.
- RD_DATA:
  - rready_o=1 throughout this state.
  - On rvalid_i: data_o_r<=data_i_r, error<=(rresp_i!=2'b00), done<=1 for one cycle, rready_o<=0, go to IDLE.
- Valid signals never drop before their handshake (AXI rule).
- addr_o and data_o hold their latched values until the next start.
- data_o_r and error hold until the next start (error is cleared at start; data_o_r is overwritten only by a read).
- Latency with zero-wait ready:
  - start sampled at edge N; valids high after N.
  - With a slave whose ready is registered from valid: handshake at N+2, B/R at N+3, done high for the cycle after N+3.
- A new start is accepted on the same edge the FSM is in IDLE, i.e. earliest one cycle after done.

Decomposition:
- Shared package axi_lite_pkg holds:
  - state enum
  - RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11
  - ADDR_W=32, DATA_W=32, STRB_W=4
- No sub-module; a single FSM module is natural.

Test Plan:
- Write: addr 0x1000, data 0xDEADBEEF, slave readies registered one cycle behind valids.
  - awvalid_o and wvalid_o rise together; wstrb_o=4'hF.
  - bready_o high in WR_RESP.
  - done pulses once with error=0; slave memory word 0 = 0xDEADBEEF.
- Read-back: read addr 0x1000.
  - arvalid_o held until arready_i.
  - done pulses; data_o_r=0xDEADBEEF; error=0.
- Error responses:
  - bresp_i=2'b10 on a write -> done with error=1.
  - A following read with rresp_i=2'b11 and data 0x12345678 -> error=1, data_o_r=0x12345678.
  - Next OKAY transaction -> error=0.
- Skewed handshake:
  - awready_i at cycle 1, wready_i at cycle 4 -> awvalid_o drops after cycle 1, wvalid_o stays high until cycle 4, bready_o is asserted only afterward, done occurs once.
- Start while busy: pulse start (read, addr 0x2000) during WR_RESP -> ignored; addr_o stays 0x1000; exactly one done.
- Reset mid-transaction: assert rst_n=0 during RD_ADDR.
  - All outputs read 0 immediately (asynchronous); no done pulse.
  - After release, a new write completes normally.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the single-outstanding AXI4-Lite master.
package axi_lite_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA
  } state_t;

endpackage

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: one start pulse becomes one write (AW/W/B)
// or one read (AR/R); all outputs are registered, done pulses for one cycle.
module axi_lite_master
  import axi_lite_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic [STRB_W-1:0] wstrb_o,
  output logic              awvalid_o,
  input  logic              awready_i,
  output logic              wvalid_o,
  input  logic              wready_i,
  input  logic [1:0]        bresp_i,
  input  logic              bvalid_i,
  output logic              bready_o,
  output logic              arvalid_o,
  input  logic              arready_i,
  input  logic [DATA_W-1:0] data_i_r,
  input  logic [1:0]        rresp_i,
  input  logic              rvalid_i,
  output logic              rready_o,
  output logic [DATA_W-1:0] data_o_r,
  output logic              error,
  output logic              done
);

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   data_reg, data_next;
  logic [STRB_W-1:0]   wstrb_reg, wstrb_next;
  logic                awvalid_reg, awvalid_next;
  logic                wvalid_reg, wvalid_next;
  logic                bready_reg, bready_next;
  logic                arvalid_reg, arvalid_next;
  logic                rready_reg, rready_next;
  logic [DATA_W-1:0]   rdata_reg, rdata_next;
  logic                error_reg, error_next;
  logic                done_reg, done_next;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic aw_complete, w_complete;

  assign aw_hs = awvalid_reg && awready_i;
  assign w_hs  = wvalid_reg && wready_i;
  assign b_hs  = bvalid_i && bready_reg;
  assign ar_hs = arvalid_reg && arready_i;
  assign r_hs  = rvalid_i && rready_reg;

  // A dropped valid inside WR_ADDR_DATA means that channel already handshook.
  assign aw_complete = !awvalid_reg || aw_hs;
  assign w_complete  = !wvalid_reg || w_hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      addr_reg    <= '0;
      data_reg    <= '0;
      wstrb_reg   <= '0;
      awvalid_reg <= 1'b0;
      wvalid_reg  <= 1'b0;
      bready_reg  <= 1'b0;
      arvalid_reg <= 1'b0;
      rready_reg  <= 1'b0;
      rdata_reg   <= '0;
      error_reg   <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      addr_reg    <= addr_next;
      data_reg    <= data_next;
      wstrb_reg   <= wstrb_next;
      awvalid_reg <= awvalid_next;
      wvalid_reg  <= wvalid_next;
      bready_reg  <= bready_next;
      arvalid_reg <= arvalid_next;
      rready_reg  <= rready_next;
      rdata_reg   <= rdata_next;
      error_reg   <= error_next;
      done_reg    <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:         if (start) state_next = we_i ? WR_ADDR_DATA : RD_ADDR;
      WR_ADDR_DATA: if (aw_complete && w_complete) state_next = WR_RESP;
      WR_RESP:      if (b_hs) state_next = IDLE;
      RD_ADDR:      if (ar_hs) state_next = RD_DATA;
      RD_DATA:      if (r_hs) state_next = IDLE;
      default:      state_next = IDLE;
    endcase
  end

  always_comb begin
    addr_next    = addr_reg;
    data_next    = data_reg;
    wstrb_next   = wstrb_reg;
    awvalid_next = awvalid_reg;
    wvalid_next  = wvalid_reg;
    bready_next  = bready_reg;
    arvalid_next = arvalid_reg;
    rready_next  = rready_reg;
    rdata_next   = rdata_reg;
    error_next   = error_reg;
    done_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          addr_next  = addr_i;
          data_next  = data_i;
          error_next = 1'b0;
          if (we_i) begin
            awvalid_next = 1'b1;
            wvalid_next  = 1'b1;
            wstrb_next   = {STRB_W{1'b1}};
          end else begin
            arvalid_next = 1'b1;
          end
        end
      end
      WR_ADDR_DATA: begin
        if (aw_hs) awvalid_next = 1'b0;
        if (w_hs) begin
          wvalid_next = 1'b0;
          wstrb_next  = '0;
        end
        if (aw_complete && w_complete) bready_next = 1'b1;
      end
      WR_RESP: begin
        if (b_hs) begin
          bready_next = 1'b0;
          error_next  = (bresp_i != RESP_OKAY);
          done_next   = 1'b1;
        end
      end
      RD_ADDR: begin
        if (ar_hs) begin
          arvalid_next = 1'b0;
          rready_next  = 1'b1;
        end
      end
      RD_DATA: begin
        if (r_hs) begin
          rdata_next  = data_i_r;
          error_next  = (rresp_i != RESP_OKAY);
          done_next   = 1'b1;
          rready_next = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign addr_o    = addr_reg;
  assign data_o    = data_reg;
  assign wstrb_o   = wstrb_reg;
  assign awvalid_o = awvalid_reg;
  assign wvalid_o  = wvalid_reg;
  assign bready_o  = bready_reg;
  assign arvalid_o = arvalid_reg;
  assign rready_o  = rready_reg;
  assign data_o_r  = rdata_reg;
  assign error     = error_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_axi_lite_master.sv
// Randomized bench for axi_lite_master: a cycle-level slave with programmable
// ready/response delays plus a transaction-level reference of memory, data and error.
module tb_axi_lite_master;
  import axi_lite_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, we_i;
  logic [31:0] addr_i, data_i;
  logic [31:0] addr_o, data_o;
  logic [3:0]  wstrb_o;
  logic        awvalid_o, awready_i, wvalid_o, wready_i;
  logic [1:0]  bresp_i;
  logic        bvalid_i, bready_o, arvalid_o, arready_i;
  logic [31:0] data_i_r;
  logic [1:0]  rresp_i;
  logic        rvalid_i, rready_o;
  logic [31:0] data_o_r;
  logic        error, done;

  axi_lite_master dut (
    .clk(clk), .rst_n(rst_n), .start(start), .we_i(we_i), .addr_i(addr_i),
    .data_i(data_i), .addr_o(addr_o), .data_o(data_o), .wstrb_o(wstrb_o),
    .awvalid_o(awvalid_o), .awready_i(awready_i), .wvalid_o(wvalid_o),
    .wready_i(wready_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i),
    .bready_o(bready_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .data_i_r(data_i_r), .rresp_i(rresp_i), .rvalid_i(rvalid_i),
    .rready_o(rready_o), .data_o_r(data_o_r), .error(error), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] ref_mem [16];
  logic [31:0] slv_mem [16];
  logic [31:0] exp_rdata;
  logic        exp_error;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_addr_o"}, addr_o, 0);
    check_eq({tag, "_data_o"}, data_o, 0);
    check_eq({tag, "_data_o_r"}, data_o_r, 0);
    check_eq({tag, "_ctrl"}, {wstrb_o, awvalid_o, wvalid_o, bready_o, arvalid_o,
                              rready_o, error, done}, 0);
  endtask

  // a_d: AW/AR ready delay, w_d: W ready delay, rsp_d: B/R response delay (cycles)
  task automatic run_txn(input bit we, input logic [31:0] addr, input logic [31:0] data,
                         input int a_d, input int w_d, input int rsp_d,
                         input logic [1:0] resp, input bit ovr, input logic [31:0] ovr_data,
                         input bit busy_start);
    int cyc = 0, done_cyc = 0, n_done = 0, a_cnt = 0, w_cnt = 0, r_cnt = 0, exp_lat;
    bit proto_ok = 1, first_ok = 0, stray = 0, rsp_sent = 0, busy_sent = 0;
    bit aw_seen = 0, w_seen = 0, ar_seen = 0;
    logic p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
    logic [31:0] s_addr = '0, s_data = '0;
    logic [3:0]  s_strb = '0;
    int idx;
    idx = int'(addr[5:2]);

    @(negedge clk);
    start = 1'b1; we_i = we; addr_i = addr; data_i = data;
    for (int k = 0; k < 300 && (n_done == 0 || cyc < done_cyc + 3); k++) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (p_awv && p_awr) aw_seen = 1;
      if (p_wv && p_wr) w_seen = 1;
      if (p_arv && p_arr) ar_seen = 1;
      // a valid may only fall on its handshake and never comes back afterwards
      if ((p_awv && !p_awr && !awvalid_o) || (aw_seen && awvalid_o)) proto_ok = 0;
      if ((p_wv && !p_wr && !wvalid_o) || (w_seen && wvalid_o)) proto_ok = 0;
      if ((p_arv && !p_arr && !arvalid_o) || (ar_seen && arvalid_o)) proto_ok = 0;
      if (bready_o && !(aw_seen && w_seen)) proto_ok = 0;
      if (rready_o && !ar_seen) proto_ok = 0;
      if (cyc == 1)
        first_ok = we ? (awvalid_o && wvalid_o && wstrb_o == 4'hF && !arvalid_o)
                      : (arvalid_o && !awvalid_o && !wvalid_o);
      if (we ? (arvalid_o || rready_o) : (awvalid_o || wvalid_o || bready_o)) stray = 1;
      if (done) begin
        n_done++;
        if (n_done == 1) done_cyc = cyc;
      end

      awready_i = awvalid_o && (a_cnt >= a_d);
      wready_i  = wvalid_o && (w_cnt >= w_d);
      arready_i = arvalid_o && (a_cnt >= a_d);
      if (awvalid_o || arvalid_o) a_cnt++;
      if (wvalid_o) w_cnt++;
      if (awready_i || arready_i) s_addr = addr_o;
      if (wready_i) begin
        s_data = data_o;
        s_strb = wstrb_o;
      end

      bvalid_i = 1'b0;
      rvalid_i = 1'b0;
      if (bready_o && !rsp_sent) begin
        if (r_cnt == rsp_d) begin
          bvalid_i = 1'b1; bresp_i = resp; rsp_sent = 1;
          if (resp == RESP_OKAY) slv_mem[s_addr[5:2]] = s_data;
        end
        r_cnt++;
        if (busy_start && !busy_sent) begin
          start = 1'b1; we_i = 1'b0; addr_i = 32'h2000; busy_sent = 1;
        end
      end
      if (rready_o && !rsp_sent) begin
        if (r_cnt == rsp_d) begin
          rvalid_i = 1'b1; rresp_i = resp; rsp_sent = 1;
          data_i_r = ovr ? ovr_data : slv_mem[s_addr[5:2]];
        end
        r_cnt++;
      end
      p_awv = awvalid_o; p_awr = awready_i;
      p_wv  = wvalid_o;  p_wr  = wready_i;
      p_arv = arvalid_o; p_arr = arready_i;
    end
    bvalid_i = 1'b0; rvalid_i = 1'b0;
    awready_i = 1'b0; wready_i = 1'b0; arready_i = 1'b0;

    if (we && resp == RESP_OKAY) ref_mem[idx] = data;
    if (!we) exp_rdata = ovr ? ovr_data : ref_mem[idx];
    exp_error = (resp != RESP_OKAY);
    exp_lat = (we ? ((a_d > w_d) ? a_d : w_d) : a_d) + rsp_d + 3;

    $display("TXN %s addr=%h data=%h resp=%0d delays=%0d/%0d/%0d done_cycle=%0d dones=%0d",
             we ? "WR" : "RD", addr, data, resp, a_d, w_d, rsp_d, done_cyc, n_done);
    check_eq("done_count", n_done, 1);
    check_eq("latency", done_cyc, exp_lat);
    check_eq("first_cycle_valids", first_ok, 1);
    check_eq("handshake_protocol", proto_ok, 1);
    check_eq("stray_channel", stray, 0);
    check_eq("slave_addr", s_addr, addr);
    check_eq("addr_o_hold", addr_o, addr);
    check_eq("data_o_hold", data_o, data);
    check_eq("wstrb_idle", wstrb_o, 0);
    check_eq("error", error, exp_error);
    check_eq("data_o_r", data_o_r, exp_rdata);
    if (we) begin
      check_eq("slave_wdata", s_data, data);
      check_eq("slave_wstrb", s_strb, 4'hF);
      check_eq("slave_mem", slv_mem[idx], ref_mem[idx]);
    end
  endtask

  initial begin
    int n_done;
    rst_n = 1'b0; start = 1'b0; we_i = 1'b0; addr_i = '0; data_i = '0;
    awready_i = 1'b0; wready_i = 1'b0; bresp_i = '0; bvalid_i = 1'b0;
    arready_i = 1'b0; data_i_r = '0; rresp_i = '0; rvalid_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      slv_mem[i] = ref_mem[i];
    end
    exp_rdata = '0;
    exp_error = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_all_zero("after_reset");

    run_txn(1, 32'h1000, 32'hDEADBEEF, 1, 1, 0, RESP_OKAY, 0, '0, 0);
    check_eq("mem_word0", slv_mem[0], 32'hDEADBEEF);
    run_txn(0, 32'h1000, $urandom, 3, 0, 0, RESP_OKAY, 0, '0, 0);
    check_eq("readback", data_o_r, 32'hDEADBEEF);

    run_txn(1, 32'h1004, $urandom, 0, 0, 1, RESP_SLVERR, 0, '0, 0);
    run_txn(0, 32'h1008, $urandom, 1, 0, 0, RESP_DECERR, 1, 32'h12345678, 0);
    check_eq("rd_err_data", data_o_r, 32'h12345678);
    run_txn(0, 32'h1000, $urandom, 0, 0, 2, RESP_OKAY, 0, '0, 0);

    run_txn(1, 32'h100C, $urandom, 1, 4, 1, RESP_OKAY, 0, '0, 0);
    run_txn(1, 32'h1000, $urandom, 1, 1, 2, RESP_OKAY, 0, '0, 1);

    for (int t = 0; t < 24; t++) begin
      logic [1:0] resp;
      resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : RESP_OKAY;
      run_txn(1'($urandom_range(0, 1)), 32'h1000 | (32'($urandom_range(0, 15)) << 2),
              $urandom, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3),
              resp, 0, '0, 0);
    end

    // abort a read while it waits in RD_ADDR
    @(negedge clk);
    start = 1'b1; we_i = 1'b0; addr_i = 32'h3000; data_i = $urandom;
    @(negedge clk);
    start = 1'b0;
    check_eq("rd_addr_pending", arvalid_o, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    n_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check_eq("no_done_on_abort", n_done, 0);
    rst_n = 1'b1;
    exp_rdata = '0;
    exp_error = 1'b0;
    run_txn(1, 32'h1010, $urandom, 1, 1, 0, RESP_OKAY, 0, '0, 0);
    run_txn(0, 32'h1010, $urandom, 1, 0, 0, RESP_OKAY, 0, '0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
